// File: rtl/pipelined_shifter.sv
// pipelined_shifter: WIDTH-bit shift/rotate unit built as SHW = log2(WIDTH) register stages.
// Stage k shifts or rotates by 2^k when bit k of the shift amount is set. A valid/ready
// handshake provides full backpressure, and results leave in acceptance order.
//
// Ports:
//   Clk      - clock, rising edge
//   Rst_n    - asynchronous active-low reset
//   InValid  - input beat valid
//   InReady  - block accepts a beat this cycle
//   In       - operand
//   Shamt    - shift amount, 0..WIDTH-1
//   Op       - 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others pass-through
//   OutValid - result valid
//   OutReady - downstream accepts the result
//   Out      - result
//   Carry    - last bit shifted/rotated out (only with SHIFTER_FLAGS_EN)
//   Zero     - Out == 0 (only with SHIFTER_FLAGS_EN)
//
// Optional feature: define SHIFTER_FLAGS_EN to add the Carry and Zero outputs.
module pipelined_shifter #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   Shamt,
    input  logic [2:0]       Op,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic             Carry,
    output logic             Zero
`endif
);

    localparam logic [2:0] OpSll = 3'b000;
    localparam logic [2:0] OpSrl = 3'b001;
    localparam logic [2:0] OpSra = 3'b010;
    localparam logic [2:0] OpRor = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;

    localparam logic [WIDTH-1:0] Ones = '1;

    logic             advance;
    logic             dec_left;
    logic             dec_rot;
    logic             dec_fill;
    logic [SHW-1:0]   dec_shamt;

    // Stage registers; stage SHW-1 is the output register.
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_q    [SHW];
    // Control travels only as far as the last stage that consumes it.
    logic [SHW-2:0]   left_q;
    logic [SHW-2:0]   rot_q;
    logic [SHW-2:0]   fill_q;
    logic [SHW-1:0]   shamt_q   [SHW-1];

    // Inputs seen by each stage's combinational shifter.
    logic [SHW-1:0]   src_valid;
    logic [SHW-1:0]   src_left;
    logic [SHW-1:0]   src_rot;
    logic [SHW-1:0]   src_fill;
    logic [SHW-1:0]   src_shamt [SHW];
    logic [WIDTH-1:0] src_data  [SHW];
    logic [WIDTH-1:0] nxt_data  [SHW];

    logic             unused_shamt;

    // The whole pipe moves together, so a stalled output register freezes every stage.
    assign advance  = !valid_q[SHW-1] || OutReady;
    assign InReady  = advance && Rst_n;
    assign OutValid = valid_q[SHW-1];
    assign Out      = data_q[SHW-1];

    // Op decoded once; pass-through ops become a zero-distance shift.
    always_comb begin
        dec_left  = 1'b0;
        dec_rot   = 1'b0;
        dec_fill  = 1'b0;
        dec_shamt = Shamt;
        case (Op)
            OpSll: dec_left = 1'b1;
            OpSrl: dec_fill = 1'b0;
            OpSra: dec_fill = In[WIDTH-1];
            OpRor: dec_rot  = 1'b1;
            OpRol: begin
                dec_left = 1'b1;
                dec_rot  = 1'b1;
            end
            default: dec_shamt = '0;
        endcase
    end

    assign src_valid = {valid_q[SHW-2:0], InValid};
    assign src_left  = {left_q, dec_left};
    assign src_rot   = {rot_q, dec_rot};
    assign src_fill  = {fill_q, dec_fill};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned N = 1 << k;

        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] left_res;
        logic [WIDTH-1:0] right_res;

        if (k == 0) begin : g_first
            assign src_data[k]  = In;
            assign src_shamt[k] = dec_shamt;
        end else begin : g_next
            assign src_data[k]  = data_q[k-1];
            assign src_shamt[k] = shamt_q[k-1];
        end

        assign d         = src_data[k];
        assign left_res  = (d << N) | (src_rot[k] ? d >> (WIDTH - N) : '0);
        assign right_res = (d >> N) |
                           (src_rot[k] ? d << (WIDTH - N) : (src_fill[k] ? ~(Ones >> N) : '0));
        // Shift amount is carried pre-shifted, so bit 0 always controls the current stage.
        assign nxt_data[k] = !src_shamt[k][0] ? d : (src_left[k] ? left_res : right_res);
    end

    // The final stage only looks at bit 0 of its shift amount.
    assign unused_shamt = ^src_shamt[SHW-1][SHW-1:1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= '0;
            left_q  <= '0;
            rot_q   <= '0;
            fill_q  <= '0;
            for (int unsigned k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
            end
            for (int unsigned k = 0; k < SHW - 1; k++) begin
                shamt_q[k] <= '0;
            end
        end else if (advance) begin
            // Bubbles move with the pipe; their data is loaded but never marked valid.
            valid_q <= src_valid;
            left_q  <= src_left[SHW-2:0];
            rot_q   <= src_rot[SHW-2:0];
            fill_q  <= src_fill[SHW-2:0];
            for (int unsigned k = 0; k < SHW; k++) begin
                data_q[k] <= nxt_data[k];
            end
            for (int unsigned k = 0; k < SHW - 1; k++) begin
                shamt_q[k] <= src_shamt[k] >> 1;
            end
        end
    end

`ifdef SHIFTER_FLAGS_EN
    logic [SHW-1:0] carry_q;
    logic [SHW-1:0] src_carry;
    logic [SHW-1:0] nxt_carry;
    logic           zero_q;

    assign src_carry = {carry_q[SHW-2:0], 1'b0};

    // Each shifting stage overwrites the carry with the last bit it pushes out; because
    // stages shift in increasing distance, the final value is the last bit out overall.
    for (genvar k = 0; k < SHW; k++) begin : g_carry
        localparam int unsigned N = 1 << k;
        assign nxt_carry[k] = !src_shamt[k][0] ? src_carry[k] :
                              (src_left[k] ? src_data[k][WIDTH-N] : src_data[k][N-1]);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            carry_q <= '0;
            zero_q  <= 1'b0;
        end else if (advance) begin
            carry_q <= nxt_carry;
            zero_q  <= (nxt_data[SHW-1] == '0);
        end
    end

    assign Carry = carry_q[SHW-1];
    assign Zero  = zero_q;
`endif

endmodule
